// File: rtl/hs_ack_gen_if.sv
// Request/acknowledge bundle between a requester and hs_ack_gen.
// The master side issues requests and flushes; the slave side answers with acks.
interface hs_ack_gen_if #(
    parameter int LATENCY = 2,
    parameter int TAG_W   = 4
);
    localparam int OUT_W = $clog2(LATENCY + 1);

    logic             req;
    logic [TAG_W-1:0] req_tag;
    logic             flush;
    logic             req_ready;
    logic             ack;
    logic [TAG_W-1:0] ack_tag;
    logic [OUT_W-1:0] outstanding;
    logic [7:0]       drop_cnt;

    modport master (
        output req,
        output req_tag,
        output flush,
        input  req_ready,
        input  ack,
        input  ack_tag,
        input  outstanding,
        input  drop_cnt
    );

    modport slave (
        input  req,
        input  req_tag,
        input  flush,
        output req_ready,
        output ack,
        output ack_tag,
        output outstanding,
        output drop_cnt
    );
endinterface

// File: rtl/hs_ack_gen.sv
// Fixed-latency request/ack responder with bounded outstanding count, flush and backpressure.
// Optional feature macro: HS_ACK_GEN_DROP_CNT_EN enables the saturating rejected-request counter.
module hs_ack_gen #(
    parameter int LATENCY = 2,
    parameter int MAX_OUT = 2,
    parameter int TAG_W   = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    hs_ack_gen_if.slave   bus
);
    localparam int OUT_W = $clog2(LATENCY + 1);
    localparam logic [OUT_W-1:0] MAX_OUT_C = OUT_W'(MAX_OUT);

    logic             ready;
    logic             accept;
    logic             retire;
    logic [TAG_W-1:0] last_tag;
    logic [OUT_W-1:0] out_q;
    logic [OUT_W-1:0] out_d;

    // A retiring ack frees its slot in the same cycle, so it also admits.
    assign ready  = !bus.flush && ((out_q < MAX_OUT_C) || retire);
    assign accept = bus.req && ready;

    // Tags are zeroed whenever a stage is invalid, so ack_tag reads 0 without an extra mux.
    for (genvar gi = 0; gi < LATENCY; gi++) begin : g_stage
        logic             vld_in;
        logic [TAG_W-1:0] tag_in;
        logic             vld_q;
        logic [TAG_W-1:0] tag_q;

        if (gi == 0) begin : g_head
            assign vld_in = accept;
            assign tag_in = accept ? bus.req_tag : '0;
        end else begin : g_body
            assign vld_in = g_stage[gi-1].vld_q;
            assign tag_in = g_stage[gi-1].tag_q;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_q <= 1'b0;
                tag_q <= '0;
            end else if (bus.flush) begin
                vld_q <= 1'b0;
                tag_q <= '0;
            end else begin
                vld_q <= vld_in;
                tag_q <= tag_in;
            end
        end
    end

    assign retire   = g_stage[LATENCY-1].vld_q;
    assign last_tag = g_stage[LATENCY-1].tag_q;

    always_comb begin
        out_d = out_q;
        if (bus.flush) begin
            out_d = '0;
        end else if (accept && !retire) begin
            out_d = out_q + 1'b1;
        end else if (!accept && retire) begin
            out_d = out_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= '0;
        end else begin
            out_q <= out_d;
        end
    end

`ifdef HS_ACK_GEN_DROP_CNT_EN
    logic [7:0] drop_q;
    logic [7:0] drop_d;

    // Counts every refused request, flush cycles included; sticks at 255.
    always_comb begin
        drop_d = drop_q;
        if (bus.req && !ready && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_q <= 8'd0;
        end else begin
            drop_q <= drop_d;
        end
    end

    assign bus.drop_cnt = drop_q;
`else
    assign bus.drop_cnt = 8'd0;
`endif

    assign bus.req_ready   = ready;
    assign bus.ack         = retire;
    assign bus.ack_tag     = last_tag;
    assign bus.outstanding = out_q;
endmodule

// File: tb/tb_hs_ack_gen.sv
// Self-checking bench for hs_ack_gen: directed scenarios then random traffic,
// compared against a queue-of-pending-requests reference model.
module tb_hs_ack_gen;
    localparam int LAT  = 3;
    localparam int MAXO = 2;
    localparam int TW   = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    hs_ack_gen_if #(.LATENCY(LAT), .TAG_W(TW)) bus ();

    hs_ack_gen #(.LATENCY(LAT), .MAX_OUT(MAXO), .TAG_W(TW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Each pending request remembers the edge at which its ack must be sampled.
    typedef struct {
        int          due;
        logic [TW-1:0] tag;
    } pend_t;

    pend_t pend_q[$];
    int    edge_n;
    int    drop_m;
    int    n_assert;
    int    n_fail;

    function automatic logic m_ack();
        return (pend_q.size() > 0) && (pend_q[0].due == edge_n + 1);
    endfunction

    function automatic logic [TW-1:0] m_tag();
        return m_ack() ? pend_q[0].tag : '0;
    endfunction

    function automatic logic m_ready(input logic f);
        return !f && ((pend_q.size() < MAXO) || m_ack());
    endfunction

    function automatic int exp_drop();
`ifdef HS_ACK_GEN_DROP_CNT_EN
        return drop_m;
`else
        return 0;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s at edge %0d: observed %0h expected %0h", name, edge_n, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("req_ready",   32'(bus.req_ready),   32'(m_ready(bus.flush)));
        chk("ack",         32'(bus.ack),         32'(m_ack()));
        chk("ack_tag",     32'(bus.ack_tag),     32'(m_tag()));
        chk("outstanding", 32'(bus.outstanding), 32'(pend_q.size()));
        chk("drop_cnt",    32'(bus.drop_cnt),    32'(exp_drop()));
        $display("edge %0d: req=%0b tag=%0h flush=%0b ready=%0b ack=%0b ack_tag=%0h out=%0d drop=%0d",
                 edge_n + 1, bus.req, bus.req_tag, bus.flush, bus.req_ready, bus.ack,
                 bus.ack_tag, bus.outstanding, bus.drop_cnt);
    endtask

    task automatic model_edge(input logic r, input logic [TW-1:0] t, input logic f);
        logic rdy;
        logic ak;
        rdy = m_ready(f);
        ak  = m_ack();
        if (f) begin
            pend_q.delete();
        end else begin
            if (ak) void'(pend_q.pop_front());
            if (r && rdy) pend_q.push_back('{due: edge_n + 1 + LAT, tag: t});
        end
        if (r && !rdy && drop_m < 255) drop_m++;
        edge_n++;
    endtask

    task automatic model_reset();
        pend_q.delete();
        drop_m = 0;
    endtask

    task automatic cycle(input logic r, input logic [TW-1:0] t, input logic f);
        bus.req     = r;
        bus.req_tag = t;
        bus.flush   = f;
        #1;
        check_all();
        @(posedge clk);
        model_edge(r, t, f);
        #1;
    endtask

    initial begin
        int k;
        logic acc;
        n_assert = 0;
        n_fail   = 0;
        edge_n   = 0;

        // Reset held over three edges with a request pending at the inputs.
        rst_n       = 1'b0;
        bus.req     = 1'b1;
        bus.req_tag = 4'h7;
        bus.flush   = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            #1;
            check_all();
            @(posedge clk);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Single request, then let it drain.
        cycle(1'b1, 4'h5, 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b0, 4'h0, 1'b0);

        // Backpressure: request held high, tag advances only on acceptance.
        k = 1;
        for (int i = 0; i < 6; i++) begin
            acc = m_ready(1'b0);
            cycle(1'b1, TW'(k), 1'b0);
            if (acc) k++;
        end
`ifdef HS_ACK_GEN_DROP_CNT_EN
        chk("bp_drop_after_6", 32'(bus.drop_cnt), 32'd2);
`else
        chk("bp_drop_after_6", 32'(bus.drop_cnt), 32'd0);
`endif
        chk("bp_tags_accepted", 32'(k - 1), 32'd4);
        for (int i = 0; i < 2; i++) begin
            acc = m_ready(1'b0);
            cycle(1'b1, TW'(k), 1'b0);
            if (acc) k++;
        end
        for (int i = 0; i < 6; i++) cycle(1'b0, 4'h0, 1'b0);

        // Flush with two requests in flight and a request in the flush cycle.
        cycle(1'b1, 4'h1, 1'b0);
        cycle(1'b1, 4'h2, 1'b0);
        cycle(1'b1, 4'h3, 1'b1);
        chk("flush_outstanding", 32'(bus.outstanding), 32'd0);
        for (int i = 0; i < 5; i++) cycle(1'b0, 4'h0, 1'b0);

        // Asynchronous reset between edges while a request is in flight.
        cycle(1'b1, 4'h9, 1'b0);
        cycle(1'b0, 4'h0, 1'b0);
        chk("pre_reset_outstanding", 32'(bus.outstanding), 32'd1);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all();
        @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) cycle(1'b0, 4'h0, 1'b0);

        // Random traffic with occasional flushes.
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom % 4) != 0, TW'($urandom), ($urandom % 20) == 0);
        end
        for (int i = 0; i < 6; i++) cycle(1'b0, 4'h0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
